// File: rtl/md_sched_if.sv
// md_sched_if: handshake and result bundle between the E stage and the multiply/divide scheduler.
//   master: E-stage side, drives the request and operands and reads status and HI/LO.
//   slave : scheduler side.
//   start/md_op/rs_val/rt_val : MD instruction request and forwarded operands
//   md_use                    : E-stage instruction touches HI/LO
//   cancel                    : flush; aborts in-flight op and blocks a same-cycle start
//   busy/stall                : operation in flight / pipeline freeze request
//   hi/lo                     : architectural HI/LO registers
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_use, cancel,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use, cancel,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the E stage. Sequences fixed-latency MULT/MULTU/DIV/DIVU
// with a down-counter, owns HI/LO, applies MTHI/MTLO immediately, and requests a pipeline stall
// while a HI/LO-touching instruction sits in E during an operation.
//   clk   : core clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : md_sched_if slave modport (request, operands, status, HI/LO)
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;

  // Arithmetic works only on latched operands so E-stage forwarding changes are ignored.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case and gives
    // truncation toward zero with the remainder carrying the dividend's sign.
    neg_a   = (op_q == OpDiv) & a_q[31];
    neg_b   = (op_q == OpDiv) & b_q[31];
    mag_a   = neg_a ? (32'd0 - a_q) : a_q;
    mag_b   = neg_b ? (32'd0 - b_q) : b_q;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / divisor;
    r_mag   = mag_a % divisor;
    quo     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem     = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = bus.start & (state_q == StIdle) & ~bus.cancel;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.md_op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              state_d = StRun;
              cnt_d   = (bus.md_op[1]) ? DivCnt : MultCnt;
              op_d    = bus.md_op;
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
            end
            OpMthi:  hi_d = bus.rs_val;
            OpMtlo:  lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (bus.cancel) begin
          // Cancel also wins over a coincident commit edge.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StIdle;
            case (op_q)
              OpMult:  {hi_d, lo_d} = prod_s;
              OpMultu: {hi_d, lo_d} = prod_u;
              OpDiv, OpDivu: begin
                // Divide by zero leaves HI/LO untouched.
                if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.stall = bus.md_use & (state_q == StRun);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: self-checking bench for md_sched. Table vectors with hand-derived results, hand
// sequences for stall/cancel/reset corner cases, and random ops against a 64-bit arithmetic model.
module tb_md_sched;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic clk;
  logic reset;

  md_sched_if bus ();

  md_sched #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op <= 3'd1) return int'(MultN);
    if (op <= 3'd3) return int'(DivN);
    return 0;
  endfunction

  // Architectural effect of one completed MD instruction on HI/LO.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      3'd0: begin r = sa * sb; m_hi = r[63:32]; m_lo = r[31:0]; end
      3'd1: begin r = ua * ub; m_hi = r[63:32]; m_lo = r[31:0]; end
      3'd2: if (rt != 0) begin
        sq = sa / sb; sr = sa % sb;
        r = sq; m_lo = r[31:0];
        r = sr; m_hi = r[31:0];
      end
      3'd3: if (rt != 0) begin
        r = ua / ub; m_lo = r[31:0];
        r = ua % ub; m_hi = r[31:0];
      end
      3'd4: m_hi = rs;
      3'd5: m_lo = rs;
      default: ;
    endcase
  endtask

  // Issue one instruction, scramble operands while busy, then check latency and HI/LO.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input string tag);
    int          n;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = m_hi;
    prev_lo = m_lo;
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    tick();
    bus.start = 1'b0;
    model_apply(op, rs, rt);
    n = 0;
    while (bus.busy && n < 100) begin
      if (n == 0) begin
        check({tag, " hi before commit"}, bus.hi, prev_hi);
        check({tag, " lo before commit"}, bus.lo, prev_lo);
      end
      n++;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      tick();
    end
    check({tag, " busy cycles"}, 32'(n), 32'(lat(op)));
    check({tag, " hi"}, bus.hi, m_hi);
    check({tag, " lo"}, bus.lo, m_lo);
  endtask

  int          n, s;
  logic [2:0]  rop;
  logic [31:0] rrs, rrt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.md_use = 1'b0; bus.cancel = 1'b0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000};
    vecs[6] = '{3'd5, 32'hCAFE_BABE, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_BABE};
    vecs[7] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d table lo", i), bus.lo, vecs[i].lo);
    end

    // MULT then MFHI in E: stall exactly MultN cycles, product visible on first free cycle.
    bus.md_use = 1'b1;
    bus.start = 1'b1; bus.md_op = 3'd0; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    #1;
    check("stall on accept cycle", 32'(bus.stall), 32'd0);
    tick();
    bus.start = 1'b0;
    model_apply(3'd0, 32'd3, 32'd5);
    n = 0;
    while (bus.stall && n < 50) begin
      n++; bus.rs_val = $urandom; bus.rt_val = $urandom; tick();
    end
    check("mfhi stall cycles", 32'(n), 32'(MultN));
    check("mfhi busy after", 32'(bus.busy), 32'd0);
    check("mfhi hi", bus.hi, m_hi);
    check("mfhi lo", bus.lo, m_lo);

    // MTLO held behind a DIV: stalled, applied only once idle.
    bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    model_apply(3'd2, 32'd100, 32'd7);
    bus.md_op = 3'd5; bus.rs_val = 32'hA5A5_A5A5;
    #1;
    n = 0; s = 0;
    while (bus.busy && n < 50) begin
      if (bus.stall) s++;
      n++; tick();
    end
    check("mtlo held busy", 32'(n), 32'(DivN));
    check("mtlo held stalls", 32'(s), 32'(DivN));
    check("div before mtlo lo", bus.lo, 32'd14);
    check("div before mtlo hi", bus.hi, 32'd2);
    tick();
    bus.start = 1'b0;
    model_apply(3'd5, 32'hA5A5_A5A5, 32'd0);
    check("mtlo applied lo", bus.lo, m_lo);
    check("mtlo no busy", 32'(bus.busy), 32'd0);
    bus.md_use = 1'b0;

    // Back-to-back MULT: second held until busy drops, accepted that cycle.
    bus.start = 1'b1; bus.md_op = 3'd0; bus.rs_val = 32'd1000; bus.rt_val = 32'd1000;
    tick();
    model_apply(3'd0, 32'd1000, 32'd1000);
    bus.rs_val = 32'hFFFF_FFFE; bus.rt_val = 32'd9;
    n = 0;
    while (bus.busy && n < 50) begin n++; tick(); end
    check("b2b first busy", 32'(n), 32'(MultN));
    check("b2b first lo", bus.lo, m_lo);
    tick();
    bus.start = 1'b0;
    model_apply(3'd0, 32'hFFFF_FFFE, 32'd9);
    n = 0;
    while (bus.busy && n < 50) begin n++; tick(); end
    check("b2b second busy", 32'(n), 32'(MultN));
    check("b2b second hi", bus.hi, m_hi);
    check("b2b second lo", bus.lo, m_lo);

    // Cancel at busy cycle 4 of DIV.
    bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel4 busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("cancel4 hi", bus.hi, m_hi);
    check("cancel4 lo", bus.lo, m_lo);

    // Cancel coincident with the commit edge.
    bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < int'(DivN) - 1; i++) tick();
    check("commit-cancel still busy", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("commit-cancel busy", 32'(bus.busy), 32'd0);
    check("commit-cancel hi", bus.hi, m_hi);
    check("commit-cancel lo", bus.lo, m_lo);

    // start & cancel together in IDLE: nothing happens.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.md_op = 3'd0;
    tick();
    check("idle cancel busy", 32'(bus.busy), 32'd0);
    bus.md_op = 3'd4; bus.rs_val = 32'hDEAD_BEEF;
    tick();
    check("idle cancel mthi", bus.hi, m_hi);
    bus.start = 1'b0; bus.cancel = 1'b0;

    // Reset at busy cycle 3 of MULT.
    bus.start = 1'b1; bus.md_op = 3'd0; bus.rs_val = 32'd77; bus.rt_val = 32'd88;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("midrun reset busy", 32'(bus.busy), 32'd0);
    check("midrun reset hi", bus.hi, 32'd0);
    check("midrun reset lo", bus.lo, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("midrun reset no commit lo", bus.lo, 32'd0);

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rrs = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rrt = 32'd0;
        1:       rrt = 32'hFFFF_FFFF;
        2:       rrt = 32'($urandom_range(1, 20));
        default: rrt = $urandom;
      endcase
      issue(rop, rrs, rrt, $sformatf("rand%0d op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the execute stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, sequences a fixed-latency multi-cycle operation with an internal down-counter, owns the HI/LO registers, and raises the stall request that freezes F/D/E while any HI/LO-touching instruction would collide with an operation in flight. Its HI/LO outputs feed the E-stage result-select mux.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is an MD operation (qualified internally by !busy)
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 ignored
- rs_val  in  32  forwarded rs operand (E stage)
- rt_val  in  32  forwarded rt operand (E stage)
- md_use  in  1  E-stage instruction reads/writes HI/LO (MFHI/MFLO/MTHI/MTLO/MULT*/DIV*)
- cancel  in  1  exception/interrupt flush; aborts in-flight op and blocks same-cycle start
- busy  out  1  operation in flight
- stall  out  1  pipeline freeze request
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Counter cnt, width covers max(MULT_CYCLES, DIV_CYCLES).
- Accept = start & !busy & !cancel. Ignored otherwise; no queuing.
- IDLE, accept, md_op 0–3: latch rs_val/rt_val/md_op, cnt ← MULT_CYCLES or DIV_CYCLES, → RUN.
- IDLE, accept, md_op 4/5: hi (or lo) ← rs_val next edge, stays IDLE, busy stays 0.
- RUN: cnt decrements each cycle; at edge with cnt==1 commit result to HI/LO, → IDLE.
- RUN, cancel=1: → IDLE next edge, cnt ← 0, HI/LO unchanged.
- busy = (state==RUN). stall = md_use & busy (combinational).
- MULT: {hi,lo} ← signed 32×32 → 64. MULTU: unsigned 64.
- DIV: lo ← signed quotient truncated toward zero, hi ← remainder with dividend sign. DIVU: unsigned.
- Divide by zero: HI/LO unchanged, full DIV_CYCLES still elapse.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Result computed from latched operands only; rs_val/rt_val changes during RUN have no effect.

## Timing
- Reset: state IDLE, cnt 0, busy 0, stall 0, hi 0, lo 0. Reset mid-RUN aborts; HI/LO zeroed, no commit.
- Accept at edge t → busy=1 cycles t+1 .. t+N (N = MULT_CYCLES/DIV_CYCLES); new HI/LO visible from cycle t+N+1, busy=0 same cycle.
- MTHI/MTLO accepted at edge t → visible cycle t+1.
- MFHI in E during busy → stall=1 every busy cycle; first non-stalled cycle reads committed value.
- Back-to-back MULT: second held by stall until busy drops, accepted the cycle busy=0.
- cancel and commit edge coincident: cancel wins, HI/LO unchanged.
- start & cancel same cycle in IDLE: no state change.

## Test plan
- Reset, then MULT rs=0xFFFFFFFF rt=0x00000002 → busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same operands → hi=0x00000001 lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7) rt=2 → busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/0 → HI/LO unchanged after 10 cycles.
- MULT then MFHI in E next cycle with md_use=1 → stall=1 exactly 5 cycles, stall=0 when hi holds product; operands changed during RUN ignored.
- MTHI rs=0x12345678 in IDLE → hi=0x12345678 next cycle, busy never asserted; MTLO during busy with md_use → stalled, not applied until IDLE.
- DIV started, cancel pulsed at busy cycle 4 → IDLE next cycle, HI/LO keep previous values; cancel on commit edge → no update.
- reset asserted at busy cycle 3 of MULT → next cycle busy=0, hi=lo=0, no later commit.
